// File: rtl/logic_op_sequencer_if.sv
// Command and response handshake bundle between a controller (master) and
// the logic-unit sequencer (slave).
interface logic_op_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_x;
   logic [3:0] cmd_y;
   logic [1:0] cmd_s;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [1:0] rsp_s;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_s, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_s
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_s, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_s
   );
endinterface

// File: rtl/logic_op_sequencer.sv
// Sequencer that drives queued commands into the 4-bit logic unit and returns results.
// Optional macro LOGIC_SEQ_CHECK_EN adds a reference model with a sticky mismatch flag.
module logic_op_sequencer #(
   parameter int SETTLE     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   logic_op_sequencer_if.slave   bus,
   output logic [3:0]            lu_x,
   output logic [3:0]            lu_y,
   output logic [1:0]            lu_s,
   input  logic [7:0]            lu_out,
   output logic                  busy,
   output logic                  mismatch
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, RESPOND} state_t;

   state_t          state, state_nxt;
   logic [9:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, empty, push, pop;
   logic            load, capture, release_rsp, dec;
   logic [3:0]      cnt;
   logic [9:0]      head;

   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign bus.cmd_ready = !full;
   assign push          = bus.cmd_valid && !full;
   assign head          = mem[rd_ptr];
   assign busy          = (state != IDLE) || !empty;

   // Storage carries data only; occupancy is tracked by the reset pointers.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.cmd_x, bus.cmd_y, bus.cmd_s};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      load        = 1'b0;
      capture     = 1'b0;
      release_rsp = 1'b0;
      dec         = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               load      = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = RESPOND;
            end else begin
               dec = 1'b1;
            end
         end
         RESPOND: begin
            if (bus.rsp_ready) begin
               release_rsp = 1'b1;
               if (!empty) begin
                  pop       = 1'b1;
                  load      = 1'b1;
                  state_nxt = DRIVE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // lu_* hold the last command after completion; only a new load changes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_x          <= '0;
         lu_y          <= '0;
         lu_s          <= '0;
         cnt           <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_s     <= '0;
      end else begin
         if (load) begin
            lu_x <= head[9:6];
            lu_y <= head[5:2];
            lu_s <= head[1:0];
            cnt  <= CNT_INIT;
         end else if (dec) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= lu_out;
            bus.rsp_s     <= lu_s;
         end else if (release_rsp) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

`ifdef LOGIC_SEQ_CHECK_EN
   function automatic logic [7:0] expected_result(input logic [3:0] x,
                                                  input logic [3:0] y,
                                                  input logic [1:0] s);
      case (s)
         2'b00:   return {4'b0, x & y};
         2'b01:   return {4'b0, x | y};
         2'b10:   return {4'b0, x ^ y};
         default: return ~{y, x};
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mismatch <= 1'b0;
      else if (capture && (lu_out != expected_result(lu_x, lu_y, lu_s)))
         mismatch <= 1'b1;
   end
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Scoreboard bench for logic_op_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on every response handshake.
module tb_logic_op_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] lu_x, lu_y;
   logic [1:0] lu_s;
   logic [7:0] lu_out;
   logic       busy, mismatch;
   logic       force_en;
   logic [7:0] force_val;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_acc;
   logic       tput_on;
   logic [9:0] exp_q [$];

`ifdef LOGIC_SEQ_CHECK_EN
   localparam logic EXP_MM = 1'b1;
`else
   localparam logic EXP_MM = 1'b0;
`endif

   logic_op_sequencer_if sif ();

   logic_op_sequencer #(.SETTLE(2), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (sif.slave),
      .lu_x     (lu_x),
      .lu_y     (lu_y),
      .lu_s     (lu_s),
      .lu_out   (lu_out),
      .busy     (busy),
      .mismatch (mismatch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural logic unit with an override for fault injection.
   always_comb begin
      lu_out = 8'h00;
      case (lu_s)
         2'b00:   lu_out = {4'b0, lu_x & lu_y};
         2'b01:   lu_out = {4'b0, lu_x | lu_y};
         2'b10:   lu_out = {4'b0, lu_x ^ lu_y};
         default: lu_out = ~{lu_y, lu_x};
      endcase
      if (force_en) lu_out = force_val;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && sif.rsp_valid && sif.rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_rsp: got data %0h, expected no response", sif.rsp_data);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("rsp_data", {24'b0, sif.rsp_data}, {24'b0, e[9:2]});
            check("rsp_s", {30'b0, sif.rsp_s}, {30'b0, e[1:0]});
            if (tput_on) begin
               if (last_acc >= 0) check("throughput", cyc - last_acc, 3);
               last_acc = cyc;
            end
         end
      end
   end

   task automatic push(input logic [3:0] x, input logic [3:0] y,
                       input logic [1:0] s, input logic [7:0] e);
      int n = 0;
      sif.cmd_valid = 1'b1;
      sif.cmd_x = x;
      sif.cmd_y = y;
      sif.cmd_s = s;
      @(negedge clk);
      while (!sif.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!sif.cmd_ready) check("push_timeout", 0, 1);
      @(posedge clk);
      if (sif.cmd_ready) exp_q.push_back({e, s});
      #1 sif.cmd_valid = 1'b0;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (exp_q.size() > 0 && n < max) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      force_en = 1'b0;
      force_val = 8'h00;
      tput_on = 1'b0;
      last_acc = -1;
      sif.cmd_valid = 1'b0;
      sif.cmd_x = '0;
      sif.cmd_y = '0;
      sif.cmd_s = '0;
      sif.rsp_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_cmd_ready", sif.cmd_ready, 1);
      check("rst_rsp_valid", sif.rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_lu", {lu_x, lu_y, lu_s}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Single AND command: latency and result.
      push(4'hC, 4'hA, 2'b00, 8'h08);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk) check("latency_early", sif.rsp_valid, 0);
      check("lu_x_loaded", lu_x, 4'hC);
      @(posedge clk);
      @(negedge clk) check("latency_rise", sif.rsp_valid, 1);
      drain(50);

      // Fill the FIFO behind a stalled response.
      sif.rsp_ready = 1'b0;
      push(4'h3, 4'h5, 2'b01, 8'h07);
      push(4'h3, 4'h5, 2'b10, 8'h06);
      push(4'h3, 4'h5, 2'b11, 8'hAC);
      push(4'h3, 4'h5, 2'b00, 8'h01);
      push(4'hF, 4'h0, 2'b10, 8'h0F);
      check("full_cmd_ready", sif.cmd_ready, 0);
      for (int i = 0; i < 5; i++) begin
         force_en = 1'b1;
         force_val = 8'(8'h5A + i * 8'h23);
         @(posedge clk);
         @(negedge clk);
         check("stall_data", sif.rsp_data, 8'h07);
         check("stall_valid", sif.rsp_valid, 1);
         check("stall_no_pop", lu_s, 2'b01);
      end
      force_en = 1'b0;
      check("busy_before_drain", busy, 1);
      @(posedge clk); #1;
      tput_on = 1'b1;
      last_acc = -1;
      sif.rsp_ready = 1'b1;
      drain(100);
      tput_on = 1'b0;
      @(negedge clk) check("busy_after", busy, 0);

      // Faulty logic unit result trips the sticky flag when checking is built in.
      @(posedge clk); #1;
      force_en = 1'b1;
      force_val = 8'hFF;
      push(4'h0, 4'h0, 2'b00, 8'hFF);
      drain(50);
      force_en = 1'b0;
      check("mismatch_set", mismatch, EXP_MM);
      push(4'h3, 4'h5, 2'b01, 8'h07);
      drain(50);
      check("mismatch_sticky", mismatch, EXP_MM);
      check("lu_hold", {lu_x, lu_y, lu_s}, {4'h3, 4'h5, 2'b01});

      // Reset while a command is settling and two more are queued.
      push(4'h1, 4'h2, 2'b00, 8'h00);
      push(4'h4, 4'h8, 2'b01, 8'h0C);
      push(4'hF, 4'hF, 2'b10, 8'h00);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("mrst_rsp_valid", sif.rsp_valid, 0);
      check("mrst_rsp", {sif.rsp_data, sif.rsp_s}, 0);
      check("mrst_lu", {lu_x, lu_y, lu_s}, 0);
      check("mrst_busy", busy, 0);
      check("mrst_mismatch", mismatch, 0);
      check("mrst_cmd_ready", sif.cmd_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("post_rst_no_rsp", sif.rsp_valid, 0);
      check("post_rst_cmd_ready", sif.cmd_ready, 1);
      check("post_rst_idle", busy, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
